mod_addsub_stream: RTL
======================

Name: mod_addsub_stream

Overview:
- Sequential, parametrised successor to the combinational modular adder.
- Computes a vector of LEN modular additions or subtractions (a ± b) mod Q, one coefficient per cycle, through a 2-stage pipeline.
- Uses a start/ready/done handshake so the key-generation controller can sequence polynomial-coefficient operations.
- Reduction is exact over the full operand range: a sum equal to Q yields 0, and carry out of DATA_WIDTH is handled.

Parameters:
- DATA_WIDTH, 32, coefficient and modulus width in bits (unsigned).
- LEN, 256, number of coefficients per job.
- n_WIDTH, 9, element counter width; 2^n_WIDTH > LEN is required.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a job; sampled only when ready=1.
- mode  input  1  0 = add, 1 = subtract (a-b); latched at start.
- Q  input  DATA_WIDTH  modulus, 2 <= Q; latched at start.
- in_valid  input  1  a/b valid this cycle.
- a  input  DATA_WIDTH  operand, expected in [0,Q).
- b  input  DATA_WIDTH  operand, expected in [0,Q).
- out_valid  output  1  out valid this cycle.
- out  output  DATA_WIDTH  reduced result.
- ready  output  1  idle; a job may start.
- done  output  1  one-cycle pulse at job end.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters=0, out=0, out_valid=0, done=0, ready=1, latched Q/mode=0. Assertion mid-job aborts the job immediately; no done pulse is issued.
- States:
  - IDLE (ready=1): on start=1, latch Q and mode, clear the counters, go to RUN. ready drops the next cycle.
  - RUN: each cycle with in_valid=1 accepts one a/b pair and increments the accept counter. When the LEN-th pair is accepted, go to DRAIN. in_valid=0 inserts a bubble; no stall or backpressure exists.
  - DRAIN: ignore in_valid. Wait until the emit counter reaches LEN (the last result has left stage 2), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE with ready=1 on the following cycle.
- Ignored inputs:
  - start outside IDLE is ignored.
  - in_valid in IDLE, DRAIN or DONE is ignored and causes no output.
  - start and in_valid in the same IDLE cycle: start is taken, the pair is dropped; the first pair is accepted no earlier than the cycle after start.
- Pipeline (latency exactly 2 cycles, in_valid at cycle t gives out_valid at t+2):
  - Stage 1 registers the (DATA_WIDTH+1)-bit raw result. Add: s = a + b with carry kept. Subtract: s = a - b as a two's-complement (DATA_WIDTH+1)-bit value.
  - Stage 2, add: out = (s >= Q) ? s - Q : s.
  - Stage 2, subtract: out = (s negative) ? s + Q : s, truncated to DATA_WIDTH.
  - Comparisons use >=, not >.
- out holds its last value when out_valid=0. out_valid is never asserted outside RUN/DRAIN.
- Operands >= Q: the same formulas apply and the result is truncated to DATA_WIDTH. There is no error indication unless the optional feature is compiled in.
- Throughput: 1 coefficient per cycle. Job time = LEN accept cycles (plus bubbles) + 2 + 1.

Optional Feature:
- Macro: MODADDSUB_RANGE_CHK_EN.
- With the macro: adds output err (1 bit, reset 0). err is set when an accepted pair has a >= Q or b >= Q (checked in stage 1). It is sticky through done and cleared on the next accepted start or on reset. Data results are unchanged.
- Without the macro: no err port and no comparators.

Test Plan:
- Add, Q=12289, pairs (12000,1000), (5,6), (12288,1), (0,0) -> outs 711, 11, 0, 0. Each appears exactly 2 cycles after its in_valid.
- Subtract, Q=12289, pairs (3,5), (5,5), (12288,0), (0,12288) -> 12287, 0, 12288, 1.
- Wide carry, DATA_WIDTH=32, add, Q=0xFFFFFFF1, a=b=0xFFFFFFF0 -> 0xFFFFFFEF. Subtract with a=0, b=0xFFFFFFF0 -> 0x00000001.
- LEN=4, in_valid pattern 1,0,1,1,0,1 -> 4 outputs in order. done pulses one cycle after the 4th out_valid, ready returns the next cycle. A start pulsed during RUN has no effect.
- Pull rst low after 2 of 4 pairs accepted -> out_valid=0, ready=1, done never pulses. A new job then completes normally with correct results.
- With MODADDSUB_RANGE_CHK_EN, Q=100, pair (150,3) -> err=1 and out=53. err stays 1 after done and clears on the next start.

Source files
------------

// File: rtl/mod_addsub_stream.sv
// Streaming modular adder/subtractor: LEN coefficients of (a +/- b) mod Q per job, 2-stage pipeline.
// Define MODADDSUB_RANGE_CHK_EN to add the sticky err output flagging operands >= Q.
module mod_addsub_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN        = 256,
  parameter int n_WIDTH    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] Q,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  ready,
  output logic                  done
`ifdef MODADDSUB_RANGE_CHK_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [n_WIDTH-1:0] LEN_M1  = n_WIDTH'(LEN - 1);
  localparam logic [n_WIDTH-1:0] LEN_CNT = n_WIDTH'(LEN);

  state_t                state_r;
  logic [n_WIDTH-1:0]    acc_cnt_r;
  logic [n_WIDTH-1:0]    emit_cnt_r;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  mode_r;
  logic                  ready_r;
  logic                  done_r;

  logic [DATA_WIDTH:0]   s1_r;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] out_r;
  logic                  out_valid_r;

  logic                  start_s;
  logic                  accept_s;
  logic [DATA_WIDTH:0]   raw_s;
  logic [DATA_WIDTH-1:0] red_s;

  // Handshake qualification, stage-1 raw arithmetic and stage-2 reduction
  always_comb begin
    start_s  = 1'b0;
    accept_s = 1'b0;
    raw_s    = {(DATA_WIDTH+1){1'b0}};
    red_s    = {DATA_WIDTH{1'b0}};
    start_s  = (state_r == ST_IDLE) && start;
    accept_s = (state_r == ST_RUN) && in_valid;
    if (mode_r) begin
      raw_s = {1'b0, a} - {1'b0, b};
    end else begin
      raw_s = {1'b0, a} + {1'b0, b};
    end
    // Truncating (s -/+ Q) equals doing the arithmetic on the low DATA_WIDTH bits.
    if (mode_r) begin
      if (s1_r[DATA_WIDTH]) begin
        red_s = s1_r[DATA_WIDTH-1:0] + q_r;
      end else begin
        red_s = s1_r[DATA_WIDTH-1:0];
      end
    end else begin
      if (s1_r >= {1'b0, q_r}) begin
        red_s = s1_r[DATA_WIDTH-1:0] - q_r;
      end else begin
        red_s = s1_r[DATA_WIDTH-1:0];
      end
    end
  end

  // Job control FSM: sequencing, accept/emit counters, latched Q/mode, ready/done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      acc_cnt_r  <= {n_WIDTH{1'b0}};
      emit_cnt_r <= {n_WIDTH{1'b0}};
      q_r        <= {DATA_WIDTH{1'b0}};
      mode_r     <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (s1_valid_r) begin
        emit_cnt_r <= emit_cnt_r + {{(n_WIDTH-1){1'b0}}, 1'b1};
      end
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b1;
          if (start_s) begin
            state_r    <= ST_RUN;
            ready_r    <= 1'b0;
            q_r        <= Q;
            mode_r     <= mode;
            acc_cnt_r  <= {n_WIDTH{1'b0}};
            emit_cnt_r <= {n_WIDTH{1'b0}};
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            acc_cnt_r <= acc_cnt_r + {{(n_WIDTH-1){1'b0}}, 1'b1};
            if (acc_cnt_r == LEN_M1) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // emit_cnt_r reaching LEN means the final result is on out this cycle.
          if (emit_cnt_r == LEN_CNT) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Two-stage datapath: raw sum/difference, then modular reduction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_r        <= {(DATA_WIDTH+1){1'b0}};
      s1_valid_r  <= 1'b0;
      out_r       <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      s1_valid_r  <= accept_s;
      out_valid_r <= s1_valid_r;
      if (accept_s) begin
        s1_r <= raw_s;
      end
      if (s1_valid_r) begin
        out_r <= red_s;
      end
    end
  end

`ifdef MODADDSUB_RANGE_CHK_EN
  logic err_r;

  // Sticky out-of-range flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (start_s) begin
      err_r <= 1'b0;
    end else if (accept_s && ((a >= q_r) || (b >= q_r))) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`endif

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign ready     = ready_r;
  assign done      = done_r;

endmodule
